// File: rtl/regfile_write_stage.sv
// Writeback stage register feeding the register file write-address decode tree,
// with write-to-read bypass on both read ports and a saturating commit counter.
module regfile_write_stage #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 31,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en_in,
   input  logic [ADDR_WIDTH-1:0] wr_addr_in,
   input  logic [DATA_WIDTH-1:0] wr_data_in,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [ADDR_WIDTH-1:0] rd_addr1,
   input  logic [ADDR_WIDTH-1:0] rd_addr2,
   input  logic [DATA_WIDTH-1:0] rf_data1,
   input  logic [DATA_WIDTH-1:0] rf_data2,
   output logic                  dec_enable,
   output logic [ADDR_WIDTH-1:0] dec_addr,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic [DATA_WIDTH-1:0] rd_data1,
   output logic [DATA_WIDTH-1:0] rd_data2,
   output logic [CNT_WIDTH-1:0]  wr_count
);

   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1'b1);

   logic                  next_enable;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [DATA_WIDTH-1:0] next_data;
   logic                  commit;
   logic [CNT_WIDTH-1:0]  next_count;

   // Stage next-state: flush beats stall, stall holds, otherwise capture.
   always_comb begin
      next_enable = dec_enable;
      next_addr   = dec_addr;
      next_data   = wb_data;
      if (flush) begin
         next_enable = 1'b0;
         next_addr   = {ADDR_WIDTH{1'b0}};
         next_data   = {DATA_WIDTH{1'b0}};
      end else if (stall) begin
         next_enable = dec_enable;
         next_addr   = dec_addr;
         next_data   = wb_data;
      end else begin
         next_enable = wr_en_in & (wr_addr_in != ZERO_ADDR);
         next_addr   = wr_addr_in;
         next_data   = wr_data_in;
      end
   end

   // Stage register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dec_enable <= 1'b0;
         dec_addr   <= {ADDR_WIDTH{1'b0}};
         wb_data    <= {DATA_WIDTH{1'b0}};
      end else begin
         dec_enable <= next_enable;
         dec_addr   <= next_addr;
         wb_data    <= next_data;
      end
   end

   // A stalled write is counted once, on the edge where it finally leaves.
   always_comb begin
      commit     = dec_enable & ~stall;
      next_count = wr_count;
      if (commit && (wr_count != CNT_MAX)) begin
         next_count = wr_count + CNT_ONE;
      end else begin
         next_count = wr_count;
      end
   end

   // Committed-write counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_count <= {CNT_WIDTH{1'b0}};
      end else begin
         wr_count <= next_count;
      end
   end

   // Bypass: ZERO_REG never matches because dec_enable is never set for it.
   always_comb begin
      rd_data1 = rf_data1;
      rd_data2 = rf_data2;
      if (dec_enable && (rd_addr1 == dec_addr)) begin
         rd_data1 = wb_data;
      end else begin
         rd_data1 = rf_data1;
      end
      if (dec_enable && (rd_addr2 == dec_addr)) begin
         rd_data2 = wb_data;
      end else begin
         rd_data2 = rf_data2;
      end
   end

endmodule
